// File: rtl/alu_execute.sv
// Execute stage: single-cycle ALU ops plus a 32-cycle iterative shift-add multiplier.
// Results, destination index and flags are registered and held until the next completion.
module alu_execute (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [3:0]  Opcode,
  input  logic [3:0]  Dest_in,
  input  logic [31:0] Operand_1,
  input  logic [31:0] Operand_2,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ALU_Result,
  output logic [3:0]  Destination,
  output logic        Write_enable,
  output logic [3:0]  Flags,
  output logic [1:0]  debug_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_LSL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  // Handshake: Start is sampled only while Busy=0; the op completes with a one-cycle Done pulse.
  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [3:0]  dest_q;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;

  logic [32:0] sum33;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic        res_wr;
  logic        flag_wr;
  logic [31:0] acc_next;

  always_comb begin
    sum33     = {1'b0, Operand_1} + {1'b0, Operand_2};
    diff      = Operand_1 - Operand_2;
    alu_res   = 32'd0;
    alu_flags = 4'd0;
    res_wr    = 1'b0;
    flag_wr   = 1'b0;
    case (Opcode)
      OP_ADD: begin
        alu_res   = sum33[31:0];
        alu_flags = {sum33[31], (sum33[31:0] == 32'd0), sum33[32],
                     (Operand_1[31] == Operand_2[31]) && (sum33[31] != Operand_1[31])};
        res_wr    = 1'b1;
        flag_wr   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res   = diff;
        alu_flags = {diff[31], (diff == 32'd0), (Operand_1 >= Operand_2),
                     (Operand_1[31] != Operand_2[31]) && (diff[31] != Operand_1[31])};
        res_wr    = (Opcode == OP_SUB);
        flag_wr   = 1'b1;
      end
      OP_AND: begin alu_res = Operand_1 & Operand_2; res_wr = 1'b1; end
      OP_ORR: begin alu_res = Operand_1 | Operand_2; res_wr = 1'b1; end
      OP_EOR: begin alu_res = Operand_1 ^ Operand_2; res_wr = 1'b1; end
      OP_MOV: begin alu_res = Operand_2;              res_wr = 1'b1; end
      OP_LSL: begin alu_res = Operand_1 << Operand_2[4:0]; res_wr = 1'b1; end
      OP_LSR: begin alu_res = Operand_1 >> Operand_2[4:0]; res_wr = 1'b1; end
      default: ;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      op_q        <= 4'd0;
      dest_q      <= 4'd0;
      mcand       <= 32'd0;
      mplier      <= 32'd0;
      acc         <= 32'd0;
      cnt         <= 5'd0;
      ALU_Result  <= 32'd0;
      Destination <= 4'd0;
      Flags       <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q   <= Opcode;
            dest_q <= Dest_in;
            if (Opcode == OP_MUL) begin
              mcand  <= Operand_1;
              mplier <= Operand_2;
              acc    <= 32'd0;
              cnt    <= 5'd0;
              state  <= S_MUL;
            end else begin
              if (res_wr) begin
                ALU_Result  <= alu_res;
                Destination <= Dest_in;
              end
              if (flag_wr) Flags <= alu_flags;
              state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          // One partial product per cycle; ALU_Result is only touched on the last one.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            ALU_Result  <= acc_next;
            Destination <= dest_q;
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy         = (state != S_IDLE);
  assign Done         = (state == S_DONE);
  assign Write_enable = Done && (op_q <= OP_MUL);
  assign debug_state  = state;

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute: hand-computed vectors for every opcode, flag
// boundaries, back-to-back issue, the iterative multiply and asynchronous reset.
module tb_alu_execute;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [3:0]  Opcode;
  logic [3:0]  Dest_in;
  logic [31:0] Operand_1;
  logic [31:0] Operand_2;
  logic        Busy;
  logic        Done;
  logic [31:0] ALU_Result;
  logic [3:0]  Destination;
  logic        Write_enable;
  logic [3:0]  Flags;
  logic [1:0]  debug_state;

  int n_total = 0;
  int n_bad   = 0;

  alu_execute dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .Opcode       (Opcode),
    .Dest_in      (Dest_in),
    .Operand_1    (Operand_1),
    .Operand_2    (Operand_2),
    .Busy         (Busy),
    .Done         (Done),
    .ALU_Result   (ALU_Result),
    .Destination  (Destination),
    .Write_enable (Write_enable),
    .Flags        (Flags),
    .debug_state  (debug_state)
  );

  // Clock / reset
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Drives one request in an IDLE cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] dest,
                       input logic [31:0] a, input logic [31:0] b);
    Opcode    = op;
    Dest_in   = dest;
    Operand_1 = a;
    Operand_2 = b;
    Start     = 1'b1;
    step();
    Start     = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [3:0] dest,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags,
                        input logic exp_we);
    issue(op, dest, a, b);
    check({tag, ".done"},  {31'd0, Done}, 32'd1);
    check({tag, ".busy"},  {31'd0, Busy}, 32'd1);
    check({tag, ".we"},    {31'd0, Write_enable}, {31'd0, exp_we});
    check({tag, ".res"},   ALU_Result, exp_res);
    check({tag, ".flags"}, {28'd0, Flags}, {28'd0, exp_flags});
    if (exp_we) check({tag, ".dest"}, {28'd0, Destination}, {28'd0, dest});
    step();
    check({tag, ".done_end"}, {31'd0, Done}, 32'd0);
    check({tag, ".idle"},     {31'd0, Busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"},  {31'd0, Busy}, 32'd0);
    check({tag, ".done"},  {31'd0, Done}, 32'd0);
    check({tag, ".we"},    {31'd0, Write_enable}, 32'd0);
    check({tag, ".res"},   ALU_Result, 32'd0);
    check({tag, ".dest"},  {28'd0, Destination}, 32'd0);
    check({tag, ".flags"}, {28'd0, Flags}, 32'd0);
    check({tag, ".state"}, {30'd0, debug_state}, 32'd0);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Start     = 1'b0;
    Opcode    = 4'd0;
    Dest_in   = 4'd0;
    Operand_1 = 32'd0;
    Operand_2 = 32'd0;
    #2;
    check_zero_outputs("reset");
    step();
    step();
    Reset_n = 1'b1;
    step();

    single("add",     4'd0, 4'd3, 32'd7, 32'd5, 32'd12, 4'b0000, 1'b1);
    single("sub_eq",  4'd1, 4'd1, 32'd5, 32'd5, 32'd0,  4'b0110, 1'b1);
    single("cmp_neg", 4'd9, 4'd2, 32'd0, 32'd1, 32'd0,  4'b1000, 1'b0);
    single("add_ovf", 4'd0, 4'd6, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001, 1'b1);

    // Back-to-back: Start stays high through DONE into the next IDLE cycle.
    issue(4'd2, 4'd7, 32'hF0F0_FFFF, 32'h0FF0_00F0);
    check("and.res",  ALU_Result, 32'h00F0_00F0);
    check("and.flags", {28'd0, Flags}, 32'h9);
    Opcode    = 4'd3;
    Dest_in   = 4'd8;
    Operand_1 = 32'h1200_0000;
    Operand_2 = 32'h0000_0034;
    Start     = 1'b1;
    step();
    check("b2b.idle", {31'd0, Busy}, 32'd0);
    step();
    Start = 1'b0;
    check("orr.done", {31'd0, Done}, 32'd1);
    check("orr.res",  ALU_Result, 32'h1200_0034);
    check("orr.dest", {28'd0, Destination}, 32'd8);
    step();

    single("eor",      4'd4, 4'd9,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b1001, 1'b1);
    single("mov",      4'd5, 4'd10, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 4'b1001, 1'b1);
    single("lsl31",    4'd6, 4'd11, 32'd1,         32'd31, 32'h8000_0000, 4'b1001, 1'b1);
    single("lsr31",    4'd7, 4'd12, 32'h8000_0000, 32'd31, 32'd1,         4'b1001, 1'b1);
    single("lsl_mask", 4'd6, 4'd13, 32'd1,         32'h0000_0023, 32'd8,  4'b1001, 1'b1);
    single("lsl0",     4'd6, 4'd14, 32'h0000_ABCD, 32'd0,  32'h0000_ABCD, 4'b1001, 1'b1);
    single("nop12",    4'd12, 4'd15, 32'd3,        32'd4,  32'h0000_ABCD, 4'b1001, 1'b0);

    // Multiply: Busy for 33 cycles, Done in cycle 33, mid-flight Start ignored.
    issue(4'd8, 4'd4, 32'h0001_0001, 32'h0001_0003);
    Operand_1 = 32'hFFFF_FFFF;
    Operand_2 = 32'hFFFF_FFFF;
    Dest_in   = 4'd0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("mul.busy%0d", c), {31'd0, Busy}, 32'd1);
      check($sformatf("mul.done%0d", c), {31'd0, Done}, 32'd0);
      check($sformatf("mul.hold%0d", c), ALU_Result, 32'h0000_ABCD);
      Start  = (c == 10);
      Opcode = (c == 10) ? 4'd0 : 4'd8;
      step();
    end
    Start = 1'b0;
    check("mul.done",  {31'd0, Done}, 32'd1);
    check("mul.busy",  {31'd0, Busy}, 32'd1);
    check("mul.we",    {31'd0, Write_enable}, 32'd1);
    check("mul.res",   ALU_Result, 32'h0004_0003);
    check("mul.dest",  {28'd0, Destination}, 32'd4);
    check("mul.flags", {28'd0, Flags}, 32'h9);
    step();
    check("mul.idle",  {31'd0, Busy}, 32'd0);
    check("mul.done_end", {31'd0, Done}, 32'd0);

    // Asynchronous reset at multiply iteration 10, between clock edges.
    issue(4'd8, 4'd5, 32'd3, 32'd3);
    for (int c = 1; c <= 10; c++) step();
    check("mulr.busy_before", {31'd0, Busy}, 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check_zero_outputs("mid_mul_reset");
    @(negedge Clock);
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;
    single("add_after_reset", 4'd0, 4'd3, 32'd7, 32'd5, 32'd12, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
